// File: rtl/line_fill_responder.sv
// Memory-side line responder: whole-line fills and write-backs against a local word array.
// Optional RESP_PERF_CNT_EN macro adds saturating fill/write-back completion counters.
module line_fill_responder #(
  parameter int LINE_WORDS = 32,
  parameter int LATENCY    = 4,
  parameter int MEM_ADDR_W = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        done,
  output logic        busy,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int LINE_W = MEM_ADDR_W - OFF_W;
  localparam int LAT_W  = $clog2(LATENCY + 2);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);
  localparam logic [LAT_W-1:0] LAST_LAT  = LAT_W'(LATENCY - 1);

  typedef enum logic [2:0] {IDLE, WAIT, RD_BURST, WR_BURST, DONE} state_t;

  state_t            state_q, state_d;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              write_q, write_d;
  logic              rd_valid_q, rd_valid_d;
  logic [31:0]       rd_data_q;
  logic              mem_we;
  logic [31:0]       mem [2**MEM_ADDR_W];
  logic              unused_addr;

  // Only the line index inside the array matters; offset and high bits alias.
  assign unused_addr = ^{req_addr[31:MEM_ADDR_W+2], req_addr[OFF_W+1:0]};

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    line_d  = line_q;
    write_d = write_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          line_d  = req_addr[MEM_ADDR_W+1:OFF_W+2];
          write_d = req_write;
          beat_d  = '0;
          lat_d   = '0;
          if (LATENCY > 0) state_d = WAIT;
          else             state_d = req_write ? WR_BURST : RD_BURST;
        end
      end
      WAIT: begin
        if (lat_q == LAST_LAT) state_d = write_q ? WR_BURST : RD_BURST;
        else                   lat_d   = lat_q + 1'b1;
      end
      RD_BURST: begin
        if (beat_q == LAST_BEAT) state_d = DONE;
        else                     beat_d  = beat_q + 1'b1;
      end
      WR_BURST: begin
        if (wr_valid) begin
          mem_we = 1'b1;
          if (beat_q == LAST_BEAT) state_d = DONE;
          else                     beat_d  = beat_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rd_valid_d = (state_d == RD_BURST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      lat_q      <= '0;
      write_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      lat_q      <= lat_d;
      write_q    <= write_d;
      rd_valid_q <= rd_valid_d;
      // Data is fetched one edge ahead so each beat is registered as it is driven.
      if (rd_valid_d) rd_data_q <= mem[{line_d, beat_d}];
    end
  end

  always_ff @(posedge clk) begin
    line_q <= line_d;
    if (mem_we && !rst) mem[{line_q, beat_q}] <= wr_data;
  end

  assign req_ready = (state_q == IDLE);
  assign wr_ready  = (state_q == WR_BURST);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

`ifdef RESP_PERF_CNT_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (state_q == DONE) begin
      if (!write_q && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (write_q && wr_cnt_q != 16'hFFFF)  wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  assign rd_count = 16'd0;
  assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_line_fill_responder.sv
// Scoreboard bench for line_fill_responder: stimulus pushes expected beats/done cycles, a monitor pops them.
module tb_line_fill_responder;
  localparam int LW  = 32;
  localparam int LAT = 4;
  localparam int MAW = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done, busy;
  logic [15:0] rd_count, wr_count;

  line_fill_responder #(.LINE_WORDS(LW), .LATENCY(LAT), .MEM_ADDR_W(MAW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .busy(busy),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {int cyc; logic [31:0] data;} beat_t;
  beat_t rd_q[$];
  int    done_q[$];
  beat_t mon_b;
  int    mon_d;

  logic [31:0] model [2**MAW];
  bit          line_known [2**MAW/LW];
  int          exp_rd_cnt = 0;
  int          exp_wr_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int line_base(input logic [31:0] addr);
    return int'((addr >> 7) % (2**MAW / LW)) * LW;
  endfunction

  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (rd_q.size() == 0) check("unexpected_rd_valid", 1, 0);
      else begin
        mon_b = rd_q.pop_front();
        check("rd_beat_cycle", cyc, mon_b.cyc);
        check("rd_data", rd_data, mon_b.data);
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        mon_d = done_q.pop_front();
        check("done_cycle", cyc, mon_d);
      end
    end
  end

  task automatic check_counts();
`ifdef RESP_PERF_CNT_EN
    check("rd_count", rd_count, exp_rd_cnt);
    check("wr_count", wr_count, exp_wr_cnt);
`else
    check("rd_count_tied", rd_count, 0);
    check("wr_count_tied", wr_count, 0);
`endif
  endtask

  task automatic wait_idle();
    int waited = 0;
    while (req_ready !== 1'b1) begin
      if (waited > 300) begin
        check("idle_timeout", 0, 1);
        return;
      end
      @(negedge clk);
      waited++;
    end
    check("busy_in_idle", busy, 0);
    check_counts();
  endtask

  // Called at a negedge; returns at the negedge following the acceptance edge.
  task automatic issue(input bit wr, input logic [31:0] addr, input int exp_acc, output int acc);
    int waited = 0;
    acc = -1;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    while (req_ready !== 1'b1) begin
      check("busy_while_not_ready", busy, 1);
      if (waited > 300) begin
        check("accept_timeout", 0, 1);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    acc = cyc;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_write = 1'($urandom);
    if (exp_acc >= 0) check("accept_cycle", acc, exp_acc);
    check("busy_after_accept", busy, 1);
  endtask

  task automatic read_line(input logic [31:0] addr, input int exp_acc, output int acc);
    int base = line_base(addr);
    issue(1'b0, addr, exp_acc, acc);
    if (acc < 0) return;
    for (int k = 0; k < LW; k++) rd_q.push_back('{cyc: acc + LAT + k, data: model[base + k]});
    done_q.push_back(acc + LAT + LW);
    exp_rd_cnt++;
    wr_valid = 1'b1;
    wr_data  = 32'hBAD0_0000 | 32'($urandom_range(0, 255));
  endtask

  task automatic write_line(input logic [31:0] addr, input bit seq, input int stall_at,
                            input int stall_len, input int abort_at);
    int base = line_base(addr);
    int acc, waited, first;
    logic [31:0] d;
    issue(1'b1, addr, -1, acc);
    if (acc < 0) return;
    wr_valid = 1'b1;
    wr_data  = 32'hDEAD_0000 | 32'($urandom_range(0, 255));
    waited = 0;
    while (wr_ready !== 1'b1) begin
      if (waited > 50) begin
        check("wr_ready_timeout", 0, 1);
        return;
      end
      @(negedge clk);
      waited++;
    end
    check("wr_ready_cycle", cyc, acc + LAT);
    for (int k = 0; k < LW; k++) begin
      if (k == abort_at) begin
        wr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_req_ready", req_ready, 1);
        check("abort_wr_ready", wr_ready, 0);
        rst = 1'b0;
        return;
      end
      if (k == stall_at) begin
        wr_valid = 1'b0;
        repeat (stall_len) begin
          @(negedge clk);
          check("wr_ready_stall", wr_ready, 1);
        end
      end
      d = seq ? 32'hA000_0000 + 32'(k) : $urandom;
      wr_valid = 1'b1;
      wr_data  = d;
      @(negedge clk);
      model[base + k] = d;
      if (k == 0) begin
        first = cyc;
        if (abort_at >= LW)
          done_q.push_back(first + LW - 1 + ((stall_at > 0 && stall_at < LW) ? stall_len : 0));
      end
    end
    wr_valid = 1'b0;
    line_known[base / LW] = 1'b1;
    exp_wr_cnt++;
  endtask

  initial begin
    int acc1, acc2, line, sl;
    logic [31:0] addr;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    wr_valid = 1'b0; wr_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_done", done, 0);
    check("rst_wr_ready", wr_ready, 0);
    check_counts();

    // write-back of words 32..63, then fill from an unaligned address in the same line
    write_line(32'h0000_0080, 1'b1, -1, 0, 99);
    wait_idle();
    read_line(32'h0000_00FF, -1, acc1);
    wait_idle();

    // write stall of 3 cycles at beat 10, read back
    write_line(32'h0000_0280, 1'b0, 10, 3, 99);
    wait_idle();
    read_line(32'h0000_0280, -1, acc1);
    wait_idle();

    // request held during a busy fill is taken only after done + one idle cycle
    read_line(32'h0000_0080, -1, acc1);
    read_line(32'h0000_0285, acc1 + LAT + LW + 2, acc2);
    wait_idle();

    // reset mid write-back at beat 5 keeps beats 0..4 new and 5..31 old
    write_line(32'h0000_0480, 1'b0, -1, 0, 99);
    wait_idle();
    write_line(32'h0000_0480, 1'b0, -1, 0, 5);
    wait_idle();
    read_line(32'h0000_0480, -1, acc1);
    wait_idle();

    // randomized traffic with aliased high address bits and random stalls
    for (int i = 0; i < 24; i++) begin
      line = $urandom_range(0, 2**MAW / LW - 1);
      addr = ($urandom & 32'hFFFF_C000) | (32'(line) << 7) | 32'($urandom_range(0, 127));
      if (!line_known[line] || $urandom_range(0, 1) == 1) begin
        sl = $urandom_range(0, 4);
        write_line(addr, 1'b0, $urandom_range(1, LW - 1), sl, 99);
      end else begin
        read_line(addr, -1, acc1);
      end
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    repeat (5) @(negedge clk);
    check("rd_queue_drained", rd_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/line_fill_responder.md
Name: line_fill_responder

Overview:
- Memory-side responder for the cache controller. It serves whole-line fill (read) and write-back (write) transactions on the cache's miss/evict interface.
- It models next-level memory with a fixed access latency and a word-per-cycle burst.
- It holds a local word array, so write-backs can be read back.
- It sits between the cache controller's memory port and the testbench/top level.

Parameters:
- LINE_WORDS, 32: 32-bit words per line. Power of two; 32 gives 128-byte lines, i.e. offset addr[6:0].
- LATENCY, 4: cycles spent in WAIT before the first data beat; 0 means WAIT is skipped.
- MEM_ADDR_W, 12: word-address width of the local array, which holds 2^MEM_ADDR_W words.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  line request present
- req_ready  out  1  responder can accept a request (IDLE only)
- req_write  in  1  1 = write-back, 0 = fill; sampled at acceptance
- req_addr  in  32  line byte address; offset bits are ignored
- wr_valid  in  1  write-back data beat present
- wr_ready  out  1  high throughout WR_BURST
- wr_data  in  32  write-back data beat
- rd_valid  out  1  fill data beat valid (no backpressure)
- rd_data  out  32  fill data beat
- done  out  1  one-cycle pulse at transaction end
- busy  out  1  high in every state except IDLE
- rd_count  out  16  completed fills (see Optional Feature)
- wr_count  out  16  completed write-backs (see Optional Feature)

Behaviour:
- Reset values: state IDLE, req_ready=1, wr_ready=0, rd_valid=0, rd_data=0, done=0, busy=0, beat and latency counters 0. Counters are 0 when enabled.
- The memory array is not reset; its contents are undefined after power-up and retained across rst.
- Acceptance happens on an edge where req_valid & req_ready. At that edge the responder latches:
  - base = {req_addr[MEM_ADDR_W+1 : log2(LINE_WORDS)+2], log2(LINE_WORDS)'b0};
  - req_write.
- Address bits above MEM_ADDR_W+1 are ignored, so addresses alias.
- FSM states: IDLE, WAIT, RD_BURST, WR_BURST, DONE.
- IDLE to WAIT on acceptance when LATENCY>0. When LATENCY=0 it goes directly to RD_BURST or WR_BURST.
- WAIT: the latency counter runs for LATENCY cycles, then the FSM enters RD_BURST if a fill was latched, else WR_BURST.
- RD_BURST, one beat per cycle:
  - rd_valid=1 and rd_data=mem[base+beat]; beat counts 0..LINE_WORDS-1.
  - rd_data is registered; the value shown is the array content when the beat is driven.
  - After beat LINE_WORDS-1 the FSM goes to DONE.
- WR_BURST:
  - wr_ready=1.
  - On each edge with wr_valid=1: mem[base+beat] <= wr_data, beat++.
  - wr_valid=0 stalls with no timeout.
  - After beat LINE_WORDS-1 is written the FSM goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Read timing: accept at edge E. The first rd_valid is in the cycle after edge E+LATENCY, the last beat follows LINE_WORDS-1 cycles later, done comes in the next cycle, and req_ready returns the cycle after done.
- Back-to-back transactions have a minimum of 1 IDLE cycle between them.
- Requests while busy (req_ready=0) are ignored; the requester must hold req_valid.
- wr_valid outside WR_BURST is ignored and does not write.
- The beat counter wraps only within the line; base is never incremented.
- rst mid-transaction: the FSM returns to IDLE immediately on the next edge with no done pulse. Beats already written stay in the array; remaining beats are not written. Counters are not incremented.

Optional Feature:
- Macro: RESP_PERF_CNT_EN.
- Defined:
  - rd_count increments in the DONE cycle of a fill; wr_count increments in the DONE cycle of a write-back.
  - Both are 16-bit, saturate at 0xFFFF, and clear on rst.
- Undefined: rd_count and wr_count are tied to 0 and no counter flops exist.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release -> req_ready=1, busy=0, rd_valid=0, done=0, counts 0.
- Write-back: accept write at 0x0000_0080, drive wr_data=0xA000_0000+k on 32 consecutive cycles ->
  - words 32..63 written;
  - done one cycle after the last beat.
- Fill after write: accept read at 0x0000_00FF (LATENCY=4) ->
  - first rd_valid in the 5th cycle after acceptance, rd_data=0xA000_0000;
  - 32 consecutive beats ending 0xA000_001F;
  - done pulse; rd_count=1 with the macro defined.
- Write stall: during write-back drop wr_valid for 3 cycles at beat 10 -> beat 10 is not advanced, data lands at correct words, done is delayed by 3 cycles.
- Busy rejection: assert req_valid with a different address during RD_BURST -> req_ready=0, no effect; the request is accepted only in IDLE after done.
- Reset mid-burst: rst during WR_BURST at beat 5 ->
  - next cycle IDLE, no done;
  - words base+0..4 hold new data, base+5..31 hold old data;
  - wr_count unchanged.
